// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain: read-side controller for the synchronous FIFO.
// Reads a BURST-word burst at half full, drains fully on flush.
//
// Ports:
//   clk, rstn              clock, async active-low reset
//   fifo_empty/half_full/full, fifo_dout   FIFO status and read data
//   fifo_re                FIFO read enable (combinational)
//   flush                  level request to drain the FIFO
//   m_valid/m_ready/m_data output stream
//   busy                   controller not idle
//   done                   one-cycle pulse after the last read issued
module fifo_burst_drain #(
    parameter int N         = 16,
    parameter int BURST     = 16,
    parameter int OUT_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         fifo_empty,
    input  logic         fifo_half_full,
    input  logic         fifo_full,
    input  logic [N-1:0] fifo_dout,
    output logic         fifo_re,
    input  logic         flush,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [N-1:0] m_data,
    output logic         busy,
    output logic         done
);

    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int OW = $clog2(OUT_DEPTH) + 1;
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [PW-1:0] PTR_LAST = PW'(OUT_DEPTH - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);
    localparam logic [OW:0]   DEPTH    = (OW + 1)'(OUT_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DRAIN
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] rd_cnt;
    logic          pend;
    logic          done_q;

    logic [N-1:0]  mem [OUT_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [OW-1:0] occ;

    logic          push;
    logic          pop;
    logic          credit;
    logic [OW:0]   used;
    logic [OW:0]   avail;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Slots already spoken for: stored words plus the read in flight.
    // A pop this cycle frees one slot in time for the new read's push.
    assign push   = pend;
    assign pop    = m_valid & m_ready;
    assign used   = {1'b0, occ} + {{OW{1'b0}}, pend};
    assign avail  = DEPTH + {{OW{1'b0}}, pop};
    assign credit = used < avail;

    assign m_valid = (occ != '0);
    assign m_data  = mem[head];
    assign done    = done_q;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (flush) begin
                    state_nx = S_DRAIN;
                end else if (fifo_half_full) begin
                    state_nx = S_BURST;
                end
            end
            S_BURST: begin
                if (fifo_re && (rd_cnt == CNT_LAST)) begin
                    state_nx = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (fifo_empty && !fifo_re) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        fifo_re = 1'b0;
        busy    = 1'b0;
        unique case (state)
            S_BURST, S_DRAIN: begin
                busy    = 1'b1;
                fifo_re = ~fifo_empty & credit;
            end
            default: begin
                fifo_re = 1'b0;
                busy    = 1'b0;
            end
        endcase
    end

    // Burst counter, read-in-flight flag and done pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_cnt <= '0;
            pend   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            pend   <= fifo_re;
            done_q <= (state != S_IDLE) && (state_nx == S_IDLE);
            if (state != S_BURST) begin
                rd_cnt <= '0;
            end else if (fifo_re) begin
                rd_cnt <= (rd_cnt == CNT_LAST) ? '0 : rd_cnt + 1'b1;
            end
        end
    end

    // Output buffer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail] <= fifo_dout;
                tail      <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // A FIFO cannot be full and empty at once.
    always @(posedge clk) begin
        if (rstn) begin
            assert (!(fifo_full && fifo_empty));
        end
    end

endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb_fifo_burst_drain: directed bench for fifo_burst_drain.
// Behavioural FIFO model feeds the DUT; outputs logged at negedge.
module tb_fifo_burst_drain;

    localparam int N = 16;

    logic         clk        = 1'b0;
    logic         rstn       = 1'b0;
    logic         fifo_empty = 1'b1;
    logic         fifo_full  = 1'b0;
    logic         hf_q       = 1'b0;
    logic         hf_en      = 1'b0;
    logic         fifo_half_full;
    logic [N-1:0] fifo_dout  = '0;
    logic         fifo_re;
    logic         flush      = 1'b0;
    logic         m_valid;
    logic         m_ready    = 1'b1;
    logic [N-1:0] m_data;
    logic         busy;
    logic         done;

    logic         wr_en   = 1'b0;
    logic [N-1:0] wr_data = '0;
    logic [N-1:0] fq [$];

    int           cyc = 0;
    int           re_log [$];
    int           done_log [$];
    int           out_cyc [$];
    logic [N-1:0] out_log [$];
    int           viol = 0;

    int           n_tests = 0;
    int           n_fail  = 0;

    assign fifo_half_full = hf_q & hf_en;

    always #5 clk = ~clk;

    fifo_burst_drain #(
        .N(N),
        .BURST(16),
        .OUT_DEPTH(4)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .fifo_empty(fifo_empty),
        .fifo_half_full(fifo_half_full),
        .fifo_full(fifo_full),
        .fifo_dout(fifo_dout),
        .fifo_re(fifo_re),
        .flush(flush),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .busy(busy),
        .done(done)
    );

    // FIFO model: 16 deep, flags and D_out update at the edge sampling re
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_re && fq.size() > 0) fifo_dout <= fq.pop_front();
        if (wr_en) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
        fifo_full  <= (fq.size() >= 16);
        hf_q       <= (fq.size() >= 8);
    end

    always @(negedge clk) begin
        if (fifo_re) re_log.push_back(cyc);
        if (fifo_re && fifo_empty) viol <= viol + 1;
        if (done) done_log.push_back(cyc);
        if (m_valid && m_ready) begin
            out_log.push_back(m_data);
            out_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [N-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = base + N'(i);
            tick(1);
        end
        wr_en = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        int b;
        tick(2);
        rstn = 1'b1;
        tick(2);
        #2 rstn = 1'b0;
        #1;
        n_tests++; if (fifo_re !== 1'b0) begin n_fail++; $display("FAIL rst_re: got %b want 0", fifo_re); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", m_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
        tick(1);
        rstn = 1'b1;
        b = re_log.size();
        tick(5);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
        n_tests++; if (re_log.size() - b != 0) begin n_fail++; $display("FAIL idle_reads: got %0d want 0", re_log.size() - b); end
    endtask

    task automatic test_burst();
        int br, bd, bo, vb, errs, lat, dgap, span;
        logic [N-1:0] exp;
        load(16'h0100, 16);
        br = re_log.size(); bd = done_log.size(); bo = out_log.size(); vb = viol;
        hf_en = 1'b1;
        tick(30);
        hf_en = 1'b0;
        n_tests++; if (re_log.size() - br != 16) begin n_fail++; $display("FAIL burst_reads: got %0d want 16", re_log.size() - br); end
        span = (re_log.size() - br >= 16) ? re_log[br+15] - re_log[br] : -1;
        n_tests++; if (span != 15) begin n_fail++; $display("FAIL burst_consec: got span %0d want 15", span); end
        n_tests++; if (done_log.size() - bd != 1) begin n_fail++; $display("FAIL burst_done_cnt: got %0d want 1", done_log.size() - bd); end
        dgap = (done_log.size() > bd && re_log.size() - br >= 16) ? done_log[bd] - re_log[br+15] : -1;
        n_tests++; if (dgap != 1) begin n_fail++; $display("FAIL burst_done_time: got %0d want 1", dgap); end
        lat = (out_cyc.size() > bo && re_log.size() > br) ? out_cyc[bo] - re_log[br] : -1;
        n_tests++; if (lat != 2) begin n_fail++; $display("FAIL burst_latency: got %0d want 2", lat); end
        errs = 0;
        for (int i = 0; i < 16; i++) begin
            exp = 16'h0100 + N'(i);
            if (bo + i >= out_log.size() || out_log[bo+i] !== exp) errs++;
        end
        n_tests++; if (errs != 0 || out_log.size() - bo != 16) begin n_fail++; $display("FAIL burst_data: got %0d words %0d bad want 16 words 0 bad", out_log.size() - bo, errs); end
        n_tests++; if (viol != vb) begin n_fail++; $display("FAIL burst_empty_read: got %0d want 0", viol - vb); end
    endtask

    task automatic test_backpressure();
        int br, bd, bo, errs;
        logic [N-1:0] exp;
        load(16'h0100, 16);
        br = re_log.size(); bd = done_log.size(); bo = out_log.size();
        m_ready = 1'b0;
        hf_en = 1'b1;
        tick(12);
        n_tests++; if (re_log.size() - br != 4) begin n_fail++; $display("FAIL bp_reads: got %0d want 4", re_log.size() - br); end
        n_tests++; if (fifo_re !== 1'b0) begin n_fail++; $display("FAIL bp_re_low: got %b want 0", fifo_re); end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (m_valid !== 1'b1 || m_data !== 16'h0100) begin
                n_fail++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=0100", m_valid, m_data);
            end
            tick(1);
        end
        m_ready = 1'b1;
        tick(30);
        hf_en = 1'b0;
        n_tests++; if (re_log.size() - br != 16) begin n_fail++; $display("FAIL bp_total_reads: got %0d want 16", re_log.size() - br); end
        errs = 0;
        for (int i = 0; i < 16; i++) begin
            exp = 16'h0100 + N'(i);
            if (bo + i >= out_log.size() || out_log[bo+i] !== exp) errs++;
        end
        n_tests++; if (errs != 0 || out_log.size() - bo != 16) begin n_fail++; $display("FAIL bp_data: got %0d words %0d bad want 16 words 0 bad", out_log.size() - bo, errs); end
        n_tests++; if (done_log.size() - bd != 1) begin n_fail++; $display("FAIL bp_done: got %0d want 1", done_log.size() - bd); end
    endtask

    task automatic test_flush();
        int br, bd, bo, vb, errs, dgap;
        logic [N-1:0] exp;
        load(16'h00A0, 5);
        br = re_log.size(); bd = done_log.size(); bo = out_log.size(); vb = viol;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(20);
        n_tests++; if (re_log.size() - br != 5) begin n_fail++; $display("FAIL flush_reads: got %0d want 5", re_log.size() - br); end
        n_tests++; if (done_log.size() - bd != 1) begin n_fail++; $display("FAIL flush_done: got %0d want 1", done_log.size() - bd); end
        dgap = (done_log.size() > bd && re_log.size() - br >= 5) ? done_log[bd] - re_log[br+4] : -1;
        n_tests++; if (dgap != 2) begin n_fail++; $display("FAIL flush_done_time: got %0d want 2", dgap); end
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            exp = 16'h00A0 + N'(i);
            if (bo + i >= out_log.size() || out_log[bo+i] !== exp) errs++;
        end
        n_tests++; if (errs != 0 || out_log.size() - bo != 5) begin n_fail++; $display("FAIL flush_data: got %0d words %0d bad want 5 words 0 bad", out_log.size() - bo, errs); end
        n_tests++; if (viol != vb) begin n_fail++; $display("FAIL flush_empty_read: got %0d want 0", viol - vb); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got %b want 0", busy); end
    endtask

    task automatic test_stall();
        int br, bd, bo, vb, errs;
        logic [N-1:0] exp;
        load(16'h0200, 10);
        br = re_log.size(); bd = done_log.size(); bo = out_log.size(); vb = viol;
        hf_en = 1'b1;
        for (int i = 0; i < 40 && re_log.size() - br < 10; i++) tick(1);
        n_tests++; if (re_log.size() - br != 10) begin n_fail++; $display("FAIL stall_first10: got %0d want 10", re_log.size() - br); end
        hf_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if (fifo_re !== 1'b0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold: got re=%b busy=%b want re=0 busy=1", fifo_re, busy);
            end
            tick(1);
        end
        load(16'h0300, 6);
        tick(15);
        n_tests++; if (re_log.size() - br != 16) begin n_fail++; $display("FAIL stall_reads: got %0d want 16", re_log.size() - br); end
        n_tests++; if (done_log.size() - bd != 1) begin n_fail++; $display("FAIL stall_done: got %0d want 1", done_log.size() - bd); end
        errs = 0;
        for (int i = 0; i < 16; i++) begin
            exp = (i < 10) ? 16'h0200 + N'(i) : 16'h0300 + N'(i - 10);
            if (bo + i >= out_log.size() || out_log[bo+i] !== exp) errs++;
        end
        n_tests++; if (errs != 0 || out_log.size() - bo != 16) begin n_fail++; $display("FAIL stall_data: got %0d words %0d bad want 16 words 0 bad", out_log.size() - bo, errs); end
        n_tests++; if (viol != vb) begin n_fail++; $display("FAIL stall_empty_read: got %0d want 0", viol - vb); end
    endtask

    task automatic test_reset_mid();
        int br, bd, bo, errs, dgap;
        logic [N-1:0] exp;
        load(16'h0100, 16);
        br = re_log.size();
        hf_en = 1'b1;
        for (int i = 0; i < 40 && re_log.size() - br < 7; i++) tick(1);
        n_tests++; if (re_log.size() - br != 7) begin n_fail++; $display("FAIL rm_pre_reads: got %0d want 7", re_log.size() - br); end
        #1 rstn = 1'b0;
        #1;
        n_tests++; if (fifo_re !== 1'b0) begin n_fail++; $display("FAIL rm_re: got %b want 0", fifo_re); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b want 0", m_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
        n_tests++; if (m_data !== 16'h0000) begin n_fail++; $display("FAIL rm_data: got %h want 0000", m_data); end
        tick(1);
        rstn = 1'b1;
        br = re_log.size(); bd = done_log.size(); bo = out_log.size();
        tick(15);
        load(16'h0110, 7);
        tick(20);
        hf_en = 1'b0;
        n_tests++; if (re_log.size() - br != 16) begin n_fail++; $display("FAIL rm_reads: got %0d want 16", re_log.size() - br); end
        n_tests++; if (done_log.size() - bd != 1) begin n_fail++; $display("FAIL rm_done: got %0d want 1", done_log.size() - bd); end
        dgap = (done_log.size() > bd && re_log.size() - br >= 16) ? done_log[bd] - re_log[br+15] : -1;
        n_tests++; if (dgap != 1) begin n_fail++; $display("FAIL rm_done_time: got %0d want 1", dgap); end
        errs = 0;
        for (int i = 0; i < 16; i++) begin
            exp = 16'h0107 + N'(i);
            if (bo + i >= out_log.size() || out_log[bo+i] !== exp) errs++;
        end
        n_tests++; if (errs != 0 || out_log.size() - bo != 16) begin n_fail++; $display("FAIL rm_data_seq: got %0d words %0d bad want 16 words 0 bad", out_log.size() - bo, errs); end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_backpressure();
        test_flush();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_burst_drain.md
Name: fifo_burst_drain

Overview:
- Downstream read-side controller for the team's synchronous FIFO. Its inputs are the FIFO's `full`, `empty`, `half_full` and `D_out`; it drives the FIFO's `re`.
- When the FIFO reaches half full it reads a fixed-length burst. On `flush` it drains the FIFO until empty.
- Words leave on a valid/ready stream through a small internal output buffer.
- It never reads an empty FIFO, so the FIFO's "No data to read" error can never fire, and it absorbs consumer backpressure without losing data.

Parameters:
- N, 16, data width; must match the FIFO's N.
- BURST, 16, words per half-full burst; normally the FIFO's M/2.
- OUT_DEPTH, 4, output buffer entries; minimum 2.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous, active-low reset
- fifo_empty  input  1  FIFO `empty` flag
- fifo_half_full  input  1  FIFO `half_full` flag
- fifo_full  input  1  FIFO `full` flag
- fifo_dout  input  N  FIFO `D_out`; valid on the cycle after `re` is sampled
- fifo_re  output  1  FIFO read enable
- flush  input  1  level request to drain the FIFO completely
- m_valid  output  1  output word valid
- m_ready  input  1  consumer ready
- m_data  output  N  output word
- busy  output  1  high when the state is not IDLE
- done  output  1  one-cycle pulse when a burst or drain finishes issuing reads

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs go to 0: `fifo_re`, `m_valid`, `m_data`, `busy`, `done`.
  - State goes to IDLE; `rd_cnt`, `pend`, buffer pointers and occupancy are cleared.
  - A read in flight when reset asserts is discarded.
- States:
  - IDLE: if `flush`, go to DRAIN (flush wins). Else if `fifo_half_full`, go to BURST with `rd_cnt`=0. Else stay.
  - BURST: issue reads while permitted. `rd_cnt` increments on each read. When the read with `rd_cnt`==BURST-1 is issued, go to IDLE and pulse `done` in the next cycle.
  - DRAIN: issue reads while permitted. When `fifo_empty`=1 and no read is issued this cycle, go to IDLE and pulse `done` in the next cycle.
  - `flush` asserted during BURST is ignored; it is re-evaluated in IDLE.
- Read rule (`fifo_re` is combinational):
  - `fifo_re` = (state is BURST or DRAIN) & ~`fifo_empty` & credit.
  - credit is true when OUT_DEPTH − occ − `pend` + (`m_valid` & `m_ready`) ≥ 1.
- Pipeline:
  - `pend` is a register set to the value of `fifo_re` each cycle.
  - When `pend`=1, `fifo_dout` is written into the buffer at that clock edge.
  - Latency is 2 cycles: `fifo_re` high in cycle c gives the word on `m_data` with `m_valid` high from cycle c+2.
  - Throughput is 1 word per cycle when `m_ready` is held at 1.
- Empty flag timing:
  - The FIFO updates `empty` at the same edge that samples `re`, so back-to-back reads are safe.
  - An empty FIFO mid-burst stalls the burst (`rd_cnt` holds); reads resume when `fifo_empty` falls.
- Output buffer:
  - Circular, OUT_DEPTH entries, with head, tail and occupancy counter of width clog2(OUT_DEPTH)+1.
  - `m_valid` = occ≠0; `m_data` = head entry. Pop happens on `m_valid` & `m_ready`.
  - Simultaneous push and pop leaves occ unchanged.
  - The credit rule guarantees the buffer never overflows.
  - `m_data` and `m_valid` hold stable while `m_valid`=1 and `m_ready`=0.
- Wrap-around: head and tail wrap modulo OUT_DEPTH; `rd_cnt` never exceeds BURST-1.
- `fifo_full` is used only as a diagnostic. An immediate assertion fires if `fifo_full`=1 while `fifo_empty`=1.

Test Plan:
- Reset check: assert `rstn`=0 mid-cycle → `fifo_re`=0, `m_valid`=0, `busy`=0 and `done`=0 immediately, without waiting for a clock edge. After release with `fifo_half_full`=0 and `flush`=0 → the block stays in IDLE with `fifo_re`=0.
- Full-rate burst: FIFO model holds 0x0100..0x010F with `half_full`=1, `m_ready`=1 → `fifo_re` is high for exactly 16 consecutive cycles. `m_data` is 0x0100..0x010F in order, starting 2 cycles after the first read. `done` pulses once, the cycle after the 16th read.
- Backpressure: same stimulus with `m_ready`=0 → `fifo_re` is high for exactly 4 cycles, then 0. `m_valid`=1 with `m_data`=0x0100 held stable. After `m_ready`=1, the remaining 12 words arrive in order with no loss or duplication.
- Flush drain: 5 words 0x00A0..0x00A4 in the FIFO, `half_full`=0, `flush` pulsed for 1 cycle → 5 reads, then `fifo_empty`=1. `done` pulses and the state returns to IDLE. `m_data` is 0x00A0..0x00A4, and there is never a `fifo_re` while `fifo_empty`=1.
- Mid-burst empty stall: the FIFO model supplies 10 words, stalls for 6 cycles with `empty`=1, then supplies 6 more → `fifo_re`=0 for the whole stall and `busy` stays 1. Exactly 16 words are output and `done` pulses once.
- Reset mid-burst: assert `rstn`=0 after 7 reads → all outputs go to 0 and `pend` is dropped. After release with `half_full`=1, a fresh burst starts with `rd_cnt`=0.
